// File: rtl/fsk_receiver.sv
// FSK receive path: counts mid-scale rising crossings per symbol window and hands
// one 4-bit symbol per window to a valid/ready holding register. Macro RX_GUARD_EN masks window-start crossings.
module fsk_receiver #(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned TH_HI       = 10,
  parameter int unsigned TH_LO       = 5,
  parameter int unsigned CNT_SHIFT   = 0,
  parameter int unsigned MIN_CROSS   = 1,
  parameter int unsigned GUARD       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dac_in,
  input  logic       sym_start,
  output logic [3:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       carrier,
  output logic       overrun,
  output logic [7:0] resync_cnt
);

  localparam int unsigned              CW      = WINDOW_LOG2 + 1;
  localparam logic [WINDOW_LOG2-1:0]   LAST    = '1;
  localparam logic [WINDOW_LOG2-1:0]   GUARD_W = WINDOW_LOG2'(GUARD);
  localparam logic [3:0]               TH_HI4  = 4'(TH_HI);
  localparam logic [3:0]               TH_LO4  = 4'(TH_LO);
  localparam logic [CW:0]              RND     = (CW+1)'((1 << CNT_SHIFT) >> 1);
`ifdef RX_GUARD_EN
  localparam bit                       GUARD_ON = 1'b1;
`else
  localparam bit                       GUARD_ON = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_sreg;
  logic                   r_level;
  logic [WINDOW_LOG2-1:0] r_win;
  logic [CW-1:0]          r_cnt;
  logic                   r_quiet;
  logic                   r_pend;
  logic [3:0]             r_sym;
  logic [3:0]             r_data;
  logic                   r_valid;
  logic                   r_overrun;
  logic [7:0]             r_resync;

  logic                   w_level_nxt, w_cross, w_count_en, w_last, w_resync, w_quiet_win;
  logic [CW-1:0]          w_cnt_fin;
  logic [CW:0]            w_sum, w_shift;
  logic [3:0]             w_sym;

  always_comb begin
    w_level_nxt = r_level;
    if (r_sreg >= TH_HI4)      w_level_nxt = 1'b1;
    else if (r_sreg <= TH_LO4) w_level_nxt = 1'b0;
    w_cross     = w_level_nxt & ~r_level;
    w_count_en  = !GUARD_ON || (r_win >= GUARD_W);
    w_cnt_fin   = (w_cross && w_count_en && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
    w_sum       = {1'b0, w_cnt_fin} + RND;
    w_shift     = w_sum >> CNT_SHIFT;
    w_sym       = (w_shift > (CW+1)'(15)) ? 4'hF : w_shift[3:0];
    w_last      = (r_win == LAST);
    // A strobe on the last sample is the normal start of the next window.
    w_resync    = sym_start && (r_win != '0) && !w_last;
    w_quiet_win = (w_cnt_fin < CW'(MIN_CROSS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (sym_start) w_state_nxt = RUN;
      RUN:  if (w_last && !w_resync && w_quiet_win && r_quiet) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg   <= '0;
      r_level  <= 1'b0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_quiet  <= 1'b0;
      r_pend   <= 1'b0;
      r_sym    <= '0;
      r_resync <= '0;
    end else begin
      r_sreg  <= dac_in;
      r_level <= w_level_nxt;
      r_pend  <= 1'b0;
      if (r_state == IDLE) begin
        r_win   <= '0;
        r_cnt   <= '0;
        r_quiet <= 1'b0;
      end else if (w_resync) begin
        r_win <= '0;
        r_cnt <= '0;
        if (r_resync != '1) r_resync <= r_resync + 1'b1;
      end else if (w_last) begin
        r_win   <= '0;
        r_cnt   <= '0;
        r_pend  <= 1'b1;
        r_sym   <= w_sym;
        r_quiet <= w_quiet_win && !r_quiet;
      end else begin
        r_win <= r_win + 1'b1;
        r_cnt <= w_cnt_fin;
      end
    end
  end

  // The closed symbol is staged one clock before entering the holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_pend) begin
      r_data  <= r_sym;
      r_valid <= 1'b1;
      if (r_valid && !data_ready) r_overrun <= 1'b1;
    end else if (r_valid && data_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign carrier    = (r_state == RUN);
  assign overrun    = r_overrun;
  assign resync_cnt = r_resync;

endmodule
